// File: rtl/sar_result_capture.sv
// rtl/sar_result_capture.sv - SAR successive-approximation result capture with single-entry output buffer
module sar_result_capture #(
    parameter bit CMP_POL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample,
    input  logic       comp_en,
    input  logic       d6,
    input  logic       d5,
    input  logic       d4,
    input  logic       d3,
    input  logic       d2,
    input  logic       d1,
    input  logic       rs,
    input  logic       comp_out,
    output logic [5:0] dac_code,
    output logic [5:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       overrun,
    output logic       seq_err
);

    typedef enum logic [1:0] {IDLE, TRACK, CONV, RESOLVE} state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [5:0] dac_q, dac_d;
    logic [5:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ovr_q, ovr_d;
    logic       serr_q, serr_d;

    logic [5:0] strobes;
    logic [5:0] ptr_mask;
    logic [5:0] result;
    logic [2:0] ptr_up;
    logic       keep;
    logic       result_evt;
    logic       seq_fault;

    always_comb begin
        strobes    = {d6, d5, d4, d3, d2, d1};
        ptr_mask   = 6'b000001 << ptr_q;
        ptr_up     = ptr_q + 3'd1;
        keep       = (comp_out == CMP_POL);
        result     = {dac_q[5:1], keep};
        state_d    = state_q;
        ptr_d      = ptr_q;
        dac_d      = dac_q;
        serr_d     = serr_q;
        result_evt = 1'b0;
        seq_fault  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rs) dac_d = '0;
                if (sample) begin
                    state_d = TRACK;
                    dac_d   = '0;
                end
            end
            TRACK: begin
                dac_d = '0;
                if (!sample) begin
                    state_d = CONV;
                    ptr_d   = 3'd5;
                end
            end
            CONV: begin
                if (sample || (strobes != 6'd0 && strobes != ptr_mask)) begin
                    seq_fault = 1'b1;
                end else if (strobes == ptr_mask) begin
                    // Trial for bit ptr and decision for the previous trial share one edge
                    dac_d[ptr_q] = 1'b1;
                    if (ptr_q != 3'd5) dac_d[ptr_up] = keep;
                    if (ptr_q == 3'd0) state_d = RESOLVE;
                    else               ptr_d   = ptr_q - 3'd1;
                end
            end
            RESOLVE: begin
                if (sample || strobes != 6'd0) begin
                    seq_fault = 1'b1;
                end else if (comp_en) begin
                    result_evt = 1'b1;
                    dac_d      = result;
                    state_d    = IDLE;
                    ptr_d      = 3'd5;
                end
            end
            default: state_d = IDLE;
        endcase

        if (seq_fault) begin
            serr_d  = 1'b1;
            dac_d   = '0;
            ptr_d   = 3'd5;
            state_d = sample ? TRACK : IDLE;
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        // A result may replace buffered data only when that data is consumed on the same edge
        if (result_evt) begin
            if (!valid_q || data_ready) begin
                data_d  = result;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd5;
            dac_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dac_q   <= dac_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            serr_q  <= serr_d;
        end
    end

    assign dac_code   = dac_q;
    assign data       = data_q;
    assign data_valid = valid_q;
    assign overrun    = ovr_q;
    assign seq_err    = serr_q;

endmodule
